// File: rtl/systolic_output_drain.sv
// ---------------------------------------------------------------------------
// systolic_output_drain
//
// Purpose:
//   Downstream stage of systolic_array. On a rising edge of compute_done the
//   full result matrix is captured into a local snapshot. The snapshot is
//   then streamed out one row per beat on a valid/ready interface, so the
//   array is free to start its next pass while results drain.
//
// Optional feature:
//   DRAIN_RELU_EN - when defined, every element on row_data passes through a
//                   ReLU on the read path (negative -> zero). The snapshot
//                   always keeps the raw values.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   compute_done   level from the array; a 0->1 transition requests capture
//   output_matrix  flat result matrix, element (r,c) at (r*cols+c)*op_width
//   abort          synchronous flush back to IDLE, snapshot discarded
//   row_data       current row, element c at c*op_width
//   row_valid      row_data/row_idx/row_last are valid
//   row_ready      consumer accepts the beat when row_valid && row_ready
//   row_idx        index of the row currently on row_data
//   row_last       high with row_valid on the final row
//   busy           snapshot held, drain in progress
//   drain_done     one-cycle pulse after the final beat is accepted
//   overrun        sticky; a capture request arrived while busy
// ---------------------------------------------------------------------------
module systolic_output_drain #(
  parameter int rows     = 64,
  parameter int cols     = 64,
  parameter int op_width = 48,
  localparam int idx_w   = (rows > 1) ? $clog2(rows) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          compute_done,
  input  logic [rows*cols*op_width-1:0] output_matrix,
  input  logic                          abort,
  output logic [cols*op_width-1:0]      row_data,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [idx_w-1:0]              row_idx,
  output logic                          row_last,
  output logic                          busy,
  output logic                          drain_done,
  output logic                          overrun
);

  localparam int row_w = cols * op_width;
  localparam logic [idx_w-1:0] last_idx = idx_w'(rows - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t            state;
  logic              prev_done;
  logic              rise;
  logic              handshake;
  logic              at_last;
  logic [row_w-1:0]  snapshot [rows];
  logic [row_w-1:0]  raw_row;
  logic [row_w-1:0]  shaped_row;

  assign rise      = compute_done && !prev_done;
  assign handshake = row_valid && row_ready;
  assign at_last   = (row_idx == last_idx);

  // Capture only happens from IDLE, so a rise during a drain can never
  // overwrite rows that are still waiting to be sent. The snapshot has no
  // reset; its contents are only observable while row_valid is high.
  always_ff @(posedge clk) begin
    if (!rst && !abort && state == IDLE && rise) begin
      for (int r = 0; r < rows; r++) begin
        snapshot[r] <= output_matrix[r*row_w +: row_w];
      end
    end
  end

  // Control FSM. abort shares the reset outcome except that the edge
  // register keeps tracking compute_done, so a rise coinciding with abort
  // is consumed and dropped rather than replayed afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_done  <= 1'b0;
      row_valid  <= 1'b0;
      row_idx    <= '0;
      busy       <= 1'b0;
      drain_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      prev_done  <= compute_done;
      drain_done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        row_valid <= 1'b0;
        row_idx   <= '0;
        busy      <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state     <= DRAIN;
              row_idx   <= '0;
              row_valid <= 1'b1;
              busy      <= 1'b1;
            end
          end
          DRAIN: begin
            if (rise) begin
              overrun <= 1'b1;
            end
            if (handshake) begin
              if (at_last) begin
                state      <= IDLE;
                row_valid  <= 1'b0;
                busy       <= 1'b0;
                row_idx    <= '0;
                drain_done <= 1'b1;
              end else begin
                row_idx <= row_idx + idx_w'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign raw_row = snapshot[row_idx];

  // Per-element read-path shaping; purely combinational so beat timing is
  // identical with or without ReLU.
  for (genvar c = 0; c < cols; c++) begin : g_elem
    logic [op_width-1:0] elem;
    assign elem = raw_row[c*op_width +: op_width];
`ifdef DRAIN_RELU_EN
    assign shaped_row[c*op_width +: op_width] = elem[op_width-1] ? '0 : elem;
`else
    assign shaped_row[c*op_width +: op_width] = elem;
`endif
  end

  // Gating with row_valid keeps row_data at zero after reset even though
  // the snapshot itself is never cleared.
  assign row_data = row_valid ? shaped_row : '0;
  assign row_last = row_valid && at_last;

endmodule

// File: tb/tb_systolic_output_drain.sv
// ---------------------------------------------------------------------------
// tb_systolic_output_drain
//
// Purpose:
//   Self-checking bench for systolic_output_drain with rows=4, cols=4,
//   op_width=16. A transaction-level model (captured matrix, next row to
//   send, sticky overrun) predicts every output on every cycle; directed
//   scenarios add literal expectations and a randomized phase follows.
//   Honours DRAIN_RELU_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_systolic_output_drain;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int OPW  = 16;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       compute_done;
  logic [ROWS*COLS*OPW-1:0]   output_matrix;
  logic                       abort;
  logic [COLS*OPW-1:0]        row_data;
  logic                       row_valid;
  logic                       row_ready;
  logic [1:0]                 row_idx;
  logic                       row_last;
  logic                       busy;
  logic                       drain_done;
  logic                       overrun;

  int vectors = 0;
  int errors  = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [OPW-1:0] m_snap [ROWS][COLS];
  bit             m_active  = 1'b0;
  int             m_next    = 0;
  bit             m_prev    = 1'b0;
  bit             m_overrun = 1'b0;
  bit             m_done    = 1'b0;
  bit             m_rise;

  // Observed handshakes
  int             hs_count = 0;
  logic [63:0]    beats_q [$];

  systolic_output_drain #(
    .rows(ROWS),
    .cols(COLS),
    .op_width(OPW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .compute_done(compute_done),
    .output_matrix(output_matrix),
    .abort(abort),
    .row_data(row_data),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_idx(row_idx),
    .row_last(row_last),
    .busy(busy),
    .drain_done(drain_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [OPW-1:0] relu16(input logic [OPW-1:0] v);
`ifdef DRAIN_RELU_EN
    return v[OPW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [63:0] counting_row(input int r, input int offset);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*OPW +: OPW] = OPW'(r*16 + c + offset);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then return at the next falling edge where
  // the outputs produced by that cycle's rising edge are stable.
  task automatic applyStimulus(input bit cd, input bit rdy, input bit ab, input bit rs);
    compute_done = cd;
    row_ready    = rdy;
    abort        = ab;
    rst          = rs;
    @(negedge clk);
  endtask

  task automatic load_counting(input int offset);
    for (int r = 0; r < ROWS; r++)
      output_matrix[r*COLS*OPW +: COLS*OPW] = counting_row(r, offset);
  endtask

  // Model: on each edge, a capture takes the whole matrix; while a snapshot
  // is held, each accepted beat advances to the next row, and the final
  // accepted row ends the drain with a done pulse.
  always @(posedge clk) begin
    m_rise = compute_done && !m_prev;
    m_prev = rst ? 1'b0 : compute_done;
    m_done = 1'b0;
    if (rst || abort) begin
      m_active  = 1'b0;
      m_next    = 0;
      m_overrun = 1'b0;
    end else if (!m_active) begin
      if (m_rise) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            m_snap[r][c] = output_matrix[(r*COLS + c)*OPW +: OPW];
        m_active = 1'b1;
        m_next   = 0;
      end
    end else begin
      if (m_rise) m_overrun = 1'b1;
      if (row_ready) begin
        if (m_next == ROWS - 1) begin
          m_active = 1'b0;
          m_next   = 0;
          m_done   = 1'b1;
        end else begin
          m_next = m_next + 1;
        end
      end
    end
  end

  // Record every accepted beat as the consumer would see it.
  always @(posedge clk) begin
    if (!rst && !abort && row_valid && row_ready) begin
      hs_count++;
      beats_q.push_back(row_data);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    logic [63:0] exp_row;
    if (check_en) begin
      exp_row = '0;
      if (m_active)
        for (int c = 0; c < COLS; c++) exp_row[c*OPW +: OPW] = relu16(m_snap[m_next][c]);
      checkOutput("row_valid",  64'(row_valid),  64'(m_active));
      checkOutput("row_idx",    64'(row_idx),    m_active ? 64'(m_next) : 64'd0);
      checkOutput("row_last",   64'(row_last),   64'(m_active && m_next == ROWS - 1));
      checkOutput("busy",       64'(busy),       64'(m_active));
      checkOutput("drain_done", 64'(drain_done), 64'(m_done));
      checkOutput("overrun",    64'(overrun),    64'(m_overrun));
      checkOutput("row_data",   row_data,        exp_row);
    end
  end

  initial begin
    logic [63:0] relu_exp;
    bit [6:0]    pat;
    bit          cd_r;
    rst = 1'b1; compute_done = 1'b0; abort = 1'b0; row_ready = 1'b0;
    output_matrix = '0;
    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    applyStimulus(0, 0, 0, 1);
    $display("[TB] reset state");
    checkOutput("rst_valid",   64'(row_valid), 64'd0);
    checkOutput("rst_busy",    64'(busy),      64'd0);
    checkOutput("rst_overrun", 64'(overrun),   64'd0);
    checkOutput("rst_data",    row_data,       64'd0);

    // Basic drain
    $display("[TB] basic drain");
    load_counting(0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("basic_row0", row_data, 64'h0003_0002_0001_0000);
    checkOutput("basic_idx0", 64'(row_idx), 64'd0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("basic_row2", row_data, 64'h0023_0022_0021_0020);
    applyStimulus(0, 1, 0, 0);
    checkOutput("basic_last", 64'(row_last), 64'd1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("basic_done", 64'(drain_done), 64'd1);
    checkOutput("basic_busy", 64'(busy), 64'd0);
    applyStimulus(0, 1, 0, 0);

    // Backpressure: ready pattern 1,0,0,1,0,1,1 (bit 0 first)
    $display("[TB] backpressure");
    hs_count = 0; beats_q.delete();
    applyStimulus(1, 1, 0, 0);
    pat = 7'b1101001;
    for (int i = 0; i < 7; i++) applyStimulus(0, pat[i], 0, 0);
    checkOutput("bp_done", 64'(drain_done), 64'd1);
    checkOutput("bp_handshakes", 64'(hs_count), 64'd4);
    for (int k = 0; k < 4 && k < beats_q.size(); k++)
      checkOutput("bp_beat", beats_q[k], counting_row(k, 0));
    applyStimulus(0, 1, 0, 0);

    // Overrun: second rise during row 1 with different data
    $display("[TB] overrun");
    beats_q.delete();
    load_counting(0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    load_counting(256);
    applyStimulus(1, 1, 0, 0);
    checkOutput("ovr_flag", 64'(overrun), 64'd1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("ovr_done", 64'(drain_done), 64'd1);
    checkOutput("ovr_beats", 64'(beats_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < beats_q.size(); k++)
      checkOutput("ovr_beat", beats_q[k], counting_row(k, 0));
    applyStimulus(1, 1, 0, 0);
    checkOutput("ovr_new_row0", row_data, 64'h0103_0102_0101_0100);
    checkOutput("ovr_sticky", 64'(overrun), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("ovr_sticky2", 64'(overrun), 64'd1);

    // Abort at row 2 while stalled
    $display("[TB] abort");
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("abt_idx2", 64'(row_idx), 64'd2);
    applyStimulus(0, 0, 1, 0);
    checkOutput("abt_valid",   64'(row_valid),  64'd0);
    checkOutput("abt_busy",    64'(busy),       64'd0);
    checkOutput("abt_overrun", 64'(overrun),    64'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("abt_nodone",  64'(drain_done), 64'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("abt_restart_idx", 64'(row_idx), 64'd0);
    checkOutput("abt_restart_row", row_data, 64'h0103_0102_0101_0100);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);

    // Reset mid-drain with compute_done held high
    $display("[TB] reset mid-drain");
    load_counting(0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("rmd_idx1", 64'(row_idx), 64'd1);
    applyStimulus(1, 1, 0, 1);
    checkOutput("rmd_valid", 64'(row_valid), 64'd0);
    checkOutput("rmd_idx",   64'(row_idx),   64'd0);
    checkOutput("rmd_data",  row_data,       64'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("rmd_recapture", 64'(row_valid), 64'd1);
    checkOutput("rmd_row0", row_data, 64'h0003_0002_0001_0000);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);

    // ReLU read path
    $display("[TB] relu row");
    output_matrix = '0;
    output_matrix[0 +: OPW]   = 16'hFFF0;
    output_matrix[OPW +: OPW] = 16'h0005;
    applyStimulus(1, 1, 0, 0);
`ifdef DRAIN_RELU_EN
    relu_exp = 64'h0000_0000_0005_0000;
`else
    relu_exp = 64'h0000_0000_0005_FFF0;
`endif
    checkOutput("relu_row0", row_data, relu_exp);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);

    // Randomized phase
    $display("[TB] random phase");
    cd_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int e = 0; e < ROWS*COLS; e++) output_matrix[e*OPW +: OPW] = OPW'($urandom);
      if ($urandom_range(5, 0) == 0) cd_r = ~cd_r;
      applyStimulus(cd_r, $urandom_range(3, 0) != 0,
                    $urandom_range(49, 0) == 0, $urandom_range(149, 0) == 0);
    end
    applyStimulus(0, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
